// File: rtl/debug_controller.sv
// UART-driven debug sequencer for the pipelined MIPS datapath: program load, run/step, state dump.
// Optional CYCLE_COUNT_EN appends a saturating enabled-cycle counter as the final dump word.
module debug_controller #(
    parameter int IMEM_AW    = 10,
    parameter int DUMP_WORDS = 33,
    parameter int DUMP_SEL_W = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [7:0]            tx_data,
    output logic                  tx_start,
    input  logic                  tx_busy,
    output logic                  pipe_en,
    output logic                  pipe_flush,
    output logic                  imem_we,
    output logic [IMEM_AW-1:0]    imem_addr,
    output logic [31:0]           imem_wdata,
    input  logic                  halt_in,
    output logic [DUMP_SEL_W-1:0] dump_sel,
    input  logic [31:0]           dump_word,
    output logic                  busy
);

`ifdef CYCLE_COUNT_EN
    localparam int NUM_WORDS = DUMP_WORDS + 1;
`else
    localparam int NUM_WORDS = DUMP_WORDS;
`endif
    localparam logic [DUMP_SEL_W-1:0] LAST_SEL = DUMP_SEL_W'(NUM_WORDS - 1);

    typedef enum logic [3:0] {
        IDLE, LD_LEN0, LD_LEN1, LD_DATA, FLUSH, STEP, RUN,
        DUMP_SEL, DUMP_LATCH, DUMP_SEND, DUMP_GAP
    } state_t;

    state_t               state, stateNext;
    logic [7:0]           lenLo;
    logic [15:0]          wordsLeft;
    logic [IMEM_AW-1:0]   addrCnt;
    logic [1:0]           byteCnt;
    logic [31:0]          shiftReg;
    logic                 takeByte, wordDone, sendNow;

    assign pipe_en = (state == RUN && !halt_in) || state == STEP;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        takeByte  = 1'b0;
        wordDone  = 1'b0;
        sendNow   = 1'b0;
        unique case (state)
            IDLE: if (rx_valid) begin
                case (rx_data)
                    8'h4C:   stateNext = LD_LEN0;
                    8'h53:   stateNext = STEP;
                    8'h52:   stateNext = RUN;
                    8'h44:   stateNext = DUMP_SEL;
                    default: stateNext = IDLE;
                endcase
            end
            LD_LEN0: if (rx_valid) stateNext = LD_LEN1;
            LD_LEN1: if (rx_valid) stateNext = ({rx_data, lenLo} == 16'd0) ? FLUSH : LD_DATA;
            LD_DATA: if (rx_valid) begin
                takeByte = 1'b1;
                if (byteCnt == 2'd3) begin
                    wordDone = 1'b1;
                    if (wordsLeft == 16'd1) stateNext = FLUSH;
                end
            end
            FLUSH:      stateNext = IDLE;
            STEP:       stateNext = DUMP_SEL;
            RUN:        if (halt_in) stateNext = DUMP_SEL;
            DUMP_SEL:   stateNext = DUMP_LATCH;
            DUMP_LATCH: stateNext = DUMP_SEND;
            DUMP_SEND: if (!tx_busy) begin
                sendNow   = 1'b1;
                stateNext = DUMP_GAP;
            end
            // byteCnt wraps to 0 after the 4th byte of a word
            DUMP_GAP: begin
                if (byteCnt != 2'd0)          stateNext = DUMP_SEND;
                else if (dump_sel == LAST_SEL) stateNext = IDLE;
                else                           stateNext = DUMP_SEL;
            end
            default: stateNext = IDLE;
        endcase
    end

`ifdef CYCLE_COUNT_EN
    logic [31:0] cycleCnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                         cycleCnt <= '0;
        else if (pipe_flush)               cycleCnt <= '0;
        else if (pipe_en && cycleCnt != '1) cycleCnt <= cycleCnt + 32'd1;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_data    <= '0;
            tx_start   <= 1'b0;
            pipe_flush <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            dump_sel   <= '0;
            busy       <= 1'b0;
            lenLo      <= '0;
            wordsLeft  <= '0;
            addrCnt    <= '0;
            byteCnt    <= '0;
            shiftReg   <= '0;
        end else begin
            imem_we    <= 1'b0;
            tx_start   <= 1'b0;
            pipe_flush <= (stateNext == FLUSH);
            busy       <= (stateNext != IDLE);

            if (state == LD_LEN0 && rx_valid) lenLo <= rx_data;
            if (state == LD_LEN1 && rx_valid) begin
                wordsLeft <= {rx_data, lenLo};
                addrCnt   <= '0;
                byteCnt   <= '0;
            end
            if (takeByte) begin
                shiftReg <= {rx_data, shiftReg[31:8]};
                byteCnt  <= byteCnt + 2'd1;
            end
            if (wordDone) begin
                imem_we    <= 1'b1;
                imem_addr  <= addrCnt;
                imem_wdata <= {rx_data, shiftReg[31:8]};
                addrCnt    <= addrCnt + 1'b1;
                wordsLeft  <= wordsLeft - 16'd1;
            end

            if (state == DUMP_LATCH) begin
`ifdef CYCLE_COUNT_EN
                shiftReg <= (dump_sel == DUMP_SEL_W'(DUMP_WORDS)) ? cycleCnt : dump_word;
`else
                shiftReg <= dump_word;
`endif
                byteCnt  <= '0;
            end
            if (sendNow) begin
                tx_data  <= shiftReg[7:0];
                tx_start <= 1'b1;
                shiftReg <= {8'h00, shiftReg[31:8]};
                byteCnt  <= byteCnt + 2'd1;
            end
            if (state == DUMP_GAP && byteCnt == 2'd0)
                dump_sel <= (dump_sel == LAST_SEL) ? '0 : dump_sel + 1'b1;
        end
    end

endmodule
